// File: rtl/uart_telemetry_arbiter.sv
// Round-robin arbiter that packs one of three 16-bit telemetry payloads into a
// 4-byte frame (header, payload hi, payload lo, XOR checksum) for a byte-wide UART.
module uart_telemetry_arbiter #(
  parameter logic [7:0] HDR_BASE  = 8'hA0,
  parameter int         NUM_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fsm_en,
  input  logic        dtr,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  ack,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        uart_tx_done,
  output logic        busy,
  output logic [7:0]  frames_sent
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_BYTES - 1);

  state_t          state;
  state_t          state_next;
  logic [1:0]      grant_id;
  logic [1:0]      last_id;
  logic [1:0]      byte_idx;
  logic [3:0][7:0] frame_q;
  logic [1:0]      rr_winner;
  logic            rr_found;
  logic            start_ok;
  logic [15:0]     sel_data;
  logic [7:0]      hdr_byte;
  int              cand;

  // Search starts just past the last served source so every requester gets a turn.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = 2'd0;
    cand      = 0;
    for (int k = 1; k <= 3; k++) begin
      cand = (int'(last_id) + k) % 3;
      if (!rr_found && req[cand]) begin
        rr_found  = 1'b1;
        rr_winner = 2'(cand);
      end
    end
  end

  assign start_ok = fsm_en && !dtr && rr_found;
  assign hdr_byte = HDR_BASE | {6'b0, grant_id};

  always_comb begin
    case (grant_id)
      2'd0:    sel_data = data0;
      2'd1:    sel_data = data1;
      default: sel_data = data2;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = LOAD;
      LOAD: state_next = SEND;
      SEND: if (!tx_busy) state_next = WAIT;
      WAIT: begin
        if (uart_tx_done) begin
          if (byte_idx == LAST_IDX) state_next = IDLE;
          else                      state_next = SEND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The payload is frozen into frame_q while ack is high, so later data changes
  // cannot corrupt a frame that is already on the wire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_id    <= 2'd0;
      last_id     <= 2'd2;
      byte_idx    <= 2'd0;
      frames_sent <= 8'h00;
      frame_q     <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) grant_id <= rr_winner;
        LOAD: begin
          frame_q[0] <= hdr_byte;
          frame_q[1] <= sel_data[15:8];
          frame_q[2] <= sel_data[7:0];
          frame_q[3] <= hdr_byte ^ sel_data[15:8] ^ sel_data[7:0];
          byte_idx   <= 2'd0;
        end
        WAIT: begin
          if (uart_tx_done) begin
            if (byte_idx == LAST_IDX) begin
              frames_sent <= frames_sent + 8'd1;
              last_id     <= grant_id;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack      = 3'b000;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != IDLE);
    case (state)
      LOAD: ack = 3'b001 << grant_id;
      SEND: begin
        tx_start = !tx_busy;
        tx_data  = frame_q[byte_idx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_telemetry_arbiter.sv
// Directed bench for uart_telemetry_arbiter: a scoreboard of expected acks and
// bytes is filled as requests are raised and drained as the DUT emits them.
module tb_uart_telemetry_arbiter;

  logic        clk;
  logic        reset;
  logic        fsm_en;
  logic        dtr;
  logic [2:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [2:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        uart_tx_done;
  logic        busy;
  logic [7:0]  frames_sent;

  logic        model_done;
  logic        stray_done;
  int          model_cnt;
  int          tx_start_count;
  int          checks;
  int          failures;

  logic [7:0]  exp_bytes[$];
  logic [2:0]  exp_acks[$];

  assign uart_tx_done = model_done | stray_done;

  uart_telemetry_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .fsm_en       (fsm_en),
    .dtr          (dtr),
    .req          (req),
    .data0        (data0),
    .data1        (data1),
    .data2        (data2),
    .ack          (ack),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .uart_tx_done (uart_tx_done),
    .busy         (busy),
    .frames_sent  (frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] new_req, input logic new_en,
                               input logic new_dtr, input logic new_busy);
    req     = new_req;
    fsm_en  = new_en;
    dtr     = new_dtr;
    tx_busy = new_busy;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic void expectFrame(input int id, input logic [15:0] d);
    logic [7:0] h;
    h = 8'hA0 | 8'(id);
    exp_acks.push_back(3'(1 << id));
    exp_bytes.push_back(h);
    exp_bytes.push_back(d[15:8]);
    exp_bytes.push_back(d[7:0]);
    exp_bytes.push_back(h ^ d[15:8] ^ d[7:0]);
  endfunction

  task automatic waitAck(input logic [2:0] mask, input string tag, output logic [2:0] got);
    got = 3'b000;
    for (int n = 0; n < 40; n++) begin
      if ((ack & mask) != 3'b000) begin
        got = ack;
        return;
      end
      step();
    end
    checkOutput({tag, "_timeout"}, 32'(ack), 32'(mask));
  endtask

  task automatic waitFrames(input logic [7:0] target, input string tag);
    for (int n = 0; n < 300; n++) begin
      if (!busy && frames_sent == target) return;
      step();
    end
    checkOutput({tag, "_timeout"}, 32'(frames_sent), 32'(target));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ack"},      32'(ack),         32'd0);
    checkOutput({tag, "_tx_start"}, 32'(tx_start),    32'd0);
    checkOutput({tag, "_tx_data"},  32'(tx_data),     32'd0);
    checkOutput({tag, "_busy"},     32'(busy),        32'd0);
    checkOutput({tag, "_frames"},   32'(frames_sent), 32'd0);
  endtask

  // Scoreboard drain: every byte strobe and every ack must match the next expectation.
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      if (tx_start === 1'b1) begin
        tx_start_count++;
        if (exp_bytes.size() == 0) checkOutput("unexpected_tx_start", 32'(tx_start), 32'd0);
        else checkOutput("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
      end
      if (ack !== 3'b000) begin
        if (exp_acks.size() == 0) checkOutput("unexpected_ack", 32'(ack), 32'd0);
        else checkOutput("ack", 32'(ack), 32'(exp_acks.pop_front()));
      end
    end
  end

  // Transmitter model: stop bit finishes three cycles after each start strobe.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      model_cnt  = 0;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (model_cnt != 0) begin
        model_cnt--;
        if (model_cnt == 0) model_done = 1'b1;
      end
      if (tx_start === 1'b1) model_cnt = 3;
    end
  end

  initial begin
    logic [2:0]  got;
    logic [2:0]  order[4];
    logic [15:0] d;
    int          c0;
    int          id;
    logic        saw_ack;

    checks         = 0;
    failures       = 0;
    tx_start_count = 0;
    model_cnt      = 0;
    model_done     = 1'b0;
    stray_done     = 1'b0;
    reset          = 1'b0;
    data0          = 16'hC0DE;
    data1          = 16'h1234;
    data2          = 16'hBEEF;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    applyStimulus(3'b111, 1'b1, 1'b0, 1'b0);

    step(); step(); step();
    checkResetOutputs("por");

    // Contention: all three request from reset; service order 0,1,2,0.
    expectFrame(0, data0);
    expectFrame(1, data1);
    expectFrame(2, data2);
    expectFrame(0, data0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitAck(3'b111, "contention_ack", got);
      checkOutput("grant_order", 32'(got), 32'(order[k]));
      req = req & ~got;
      step();
      if (k == 0) req[0] = 1'b1;
    end
    waitFrames(8'd4, "contention_done");
    checkOutput("contention_frames", 32'(frames_sent), 32'd4);

    // Single source with payload changed after capture.
    exp_acks.push_back(3'b010);
    exp_bytes.push_back(8'hA1);
    exp_bytes.push_back(8'h12);
    exp_bytes.push_back(8'h34);
    exp_bytes.push_back(8'h87);
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b0);
    waitAck(3'b010, "single_ack", got);
    checkOutput("single_ack_val", 32'(got), 32'h2);
    checkOutput("single_busy_load", 32'(busy), 32'd1);
    req = 3'b000;
    step();
    data1 = 16'hFFFF;
    waitFrames(8'd5, "single_done");
    checkOutput("single_frames", 32'(frames_sent), 32'd5);
    checkOutput("single_busy_fall", 32'(busy), 32'd0);

    // Host flow control blocks new grants but not a frame in flight.
    applyStimulus(3'b001, 1'b1, 1'b1, 1'b0);
    saw_ack = 1'b0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (ack !== 3'b000) saw_ack = 1'b1;
    end
    checkOutput("dtr_blocks_ack", 32'(saw_ack), 32'd0);
    expectFrame(0, data0);
    dtr = 1'b0;
    step();
    checkOutput("dtr_release_ack", 32'(ack), 32'h1);
    req = 3'b000;
    c0 = tx_start_count;
    for (int n = 0; n < 20 && tx_start_count == c0; n++) step();
    dtr = 1'b1;
    waitFrames(8'd6, "dtr_mid_done");
    checkOutput("dtr_mid_frames", 32'(frames_sent), 32'd6);
    dtr = 1'b0;

    // Transmitter stall holds SEND; a stray done there must be ignored.
    data1 = 16'h5A5A;
    expectFrame(1, data1);
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b1);
    waitAck(3'b010, "stall_ack", got);
    req = 3'b000;
    c0 = tx_start_count;
    for (int n = 0; n < 20; n++) begin
      stray_done = (n == 5);
      step();
    end
    stray_done = 1'b0;
    checkOutput("stall_no_start", 32'(tx_start_count - c0), 32'd0);
    tx_busy = 1'b0;
    step(); step(); step();
    checkOutput("stall_single_pulse", 32'(tx_start_count - c0), 32'd1);
    waitFrames(8'd7, "stall_done");
    checkOutput("stall_frames", 32'(frames_sent), 32'd7);

    // Reset after the second byte aborts the frame; held req is re-served.
    expectFrame(0, data0);
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0);
    waitAck(3'b001, "rst_ack", got);
    c0 = tx_start_count;
    for (int n = 0; n < 100 && tx_start_count < c0 + 2; n++) step();
    checkOutput("rst_bytes_before", 32'(tx_start_count - c0), 32'd2);
    reset = 1'b0;
    #1;
    checkResetOutputs("midrst");
    exp_bytes.delete();
    exp_acks.delete();
    c0 = tx_start_count;
    step(); step();
    checkOutput("rst_no_start", 32'(tx_start_count - c0), 32'd0);
    expectFrame(0, data0);
    reset = 1'b1;
    waitAck(3'b001, "rst_reserve_ack", got);
    checkOutput("rst_reserve_ack_val", 32'(got), 32'h1);
    req = 3'b000;
    waitFrames(8'd1, "rst_done");
    checkOutput("rst_frames", 32'(frames_sent), 32'd1);

    // Frame counter wrap: 255 more frames bring the count to 256 -> 0.
    for (int i = 0; i < 255; i++) begin
      id = i % 3;
      d  = 16'($urandom);
      if (id == 0) data0 = d;
      else if (id == 1) data1 = d;
      else data2 = d;
      expectFrame(id, d);
      req = 3'(1 << id);
      waitAck(3'b111, "wrap_ack", got);
      req = 3'b000;
      waitFrames(8'(i + 2), "wrap_done");
      if (i == 253) checkOutput("wrap_ff", 32'(frames_sent), 32'hFF);
    end
    checkOutput("wrap_zero", 32'(frames_sent), 32'd0);

    step(); step();
    checkOutput("bytes_drained", 32'(exp_bytes.size()), 32'd0);
    checkOutput("acks_drained", 32'(exp_acks.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
